transpose_buffer: RTL and testbench

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

---
 rtl/transpose_buffer.sv | 114 +++++++++++
 tb/tb_transpose_buffer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_buffer.sv
// Ping-pong N x N transpose buffer.
// Rows are written into one bank while the other bank is read out either as
// columns (transpose) or as rows (pass-through). The mode is captured with the
// first row of each block, so every block carries its own mode.
// Storage has no reset; the output is gated by out_valid so stale contents
// from a discarded block can never reach out_data.
module transpose_buffer #(
    parameter int DATA_W = 10,
    parameter int N      = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DATA_W-1:0]  in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*DATA_W-1:0]  out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last
);

    localparam int            IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [N*DATA_W-1:0] bank [2][N];

    logic [1:0]    full;
    logic [1:0]    mode;
    logic          wr_sel;
    logic          rd_sel;
    logic [IW-1:0] wr_row;
    logic [IW-1:0] rd_idx;

    logic          in_fire;
    logic          out_fire;
    logic          wr_done;
    logic          rd_done;

    logic [N*DATA_W-1:0] row_vec;
    logic [N*DATA_W-1:0] col_vec;

    // Handshakes depend only on registered flags, never on in_valid/out_ready.
    assign in_ready  = ~full[wr_sel];
    assign out_valid = full[rd_sel];

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign wr_done  = in_fire & (wr_row == LAST);
    assign rd_done  = out_fire & (rd_idx == LAST);

    // Control state: write/read pointers, bank selects, full and mode flags.
    // A completing write and a completing read always target different banks
    // (one needs the bank empty, the other needs it full), so both full
    // updates land in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            full   <= '0;
            mode   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_row <= '0;
            rd_idx <= '0;
        end else begin
            if (in_fire) begin
                wr_row <= wr_done ? '0 : wr_row + 1'b1;
                if (wr_row == '0) begin
                    mode[wr_sel] <= in_mode;
                end
                if (wr_done) begin
                    wr_sel <= ~wr_sel;
                end
            end
            if (out_fire) begin
                rd_idx <= rd_done ? '0 : rd_idx + 1'b1;
                if (rd_done) begin
                    rd_sel <= ~rd_sel;
                end
            end
            if (wr_done) begin
                full[wr_sel] <= 1'b1;
            end
            if (rd_done) begin
                full[rd_sel] <= 1'b0;
            end
        end
    end

    // Row storage; a write is only possible into a bank that is not full.
    always_ff @(posedge CLK) begin
        if (in_fire) begin
            bank[wr_sel][wr_row] <= in_data;
        end
    end

    assign row_vec = bank[rd_sel][rd_idx];

    for (genvar k = 0; k < N; k++) begin : g_col
        assign col_vec[k*DATA_W +: DATA_W] = bank[rd_sel][k][rd_idx*DATA_W +: DATA_W];
    end

    // Output vector select, forced to zero whenever nothing is presented.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = mode[rd_sel] ? row_vec : col_vec;
        end
    end

    assign out_idx  = rd_idx;
    assign out_last = out_valid & (rd_idx == LAST);

endmodule

// File: tb/tb_transpose_buffer.sv
// Scoreboard bench for transpose_buffer: one 8x10 instance and one 4x16 instance.
// Stimulus pushes expected vectors into per-instance queues; monitors pop and
// compare on every output transfer.
module tb_transpose_buffer;

    logic        CLK;
    logic        RST;

    logic        a_in_valid, a_in_ready, a_in_mode;
    logic [79:0] a_in_data;
    logic        a_out_valid, a_out_ready, a_out_last;
    logic [79:0] a_out_data;
    logic [2:0]  a_out_idx;

    logic        b_in_valid, b_in_ready, b_in_mode;
    logic [63:0] b_in_data;
    logic        b_out_valid, b_out_ready, b_out_last;
    logic [63:0] b_out_data;
    logic [1:0]  b_out_idx;

    typedef struct {
        logic [79:0] data;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int fires = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    transpose_buffer #(.DATA_W(10), .N(8)) u_a (
        .CLK(CLK), .RST(RST),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last)
    );

    transpose_buffer #(.DATA_W(16), .N(4)) u_b (
        .CLK(CLK), .RST(RST),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the 8x10 instance.
    always @(negedge CLK) begin
        if (a_out_valid && a_out_ready) begin
            fires++;
            if (fires == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (sb_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected: got idx %0d data 0x%0h, expected no output", a_out_idx, a_out_data);
            end else begin
                ea = sb_a.pop_front();
                check("a_data", a_out_data, ea.data);
                check("a_idx", 80'(a_out_idx), 80'(ea.idx));
                check("a_last", 80'(a_out_last), 80'(ea.last));
            end
        end
    end

    // Monitor for the 4x16 instance.
    always @(negedge CLK) begin
        if (b_out_valid && b_out_ready) begin
            if (sb_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected: got idx %0d data 0x%0h, expected no output", b_out_idx, b_out_data);
            end else begin
                eb = sb_b.pop_front();
                check("b_data", 80'(b_out_data), eb.data);
                check("b_idx", 80'(b_out_idx), 80'(eb.idx));
                check("b_last", 80'(b_out_last), 80'(eb.last));
            end
        end
    end

    // Row r element k of a block is base + 8r + k.
    task automatic push_a(input int base, input logic m);
        exp_t e;
        for (int v = 0; v < 8; v++) begin
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                e.data[k*10 +: 10] = m ? 10'(base + 8*v + k) : 10'(base + 8*k + v);
            end
            e.idx  = 3'(v);
            e.last = (v == 7);
            sb_a.push_back(e);
        end
    endtask

    function automatic logic [79:0] row_a(input int base, input int r);
        logic [79:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*10 +: 10] = 10'(base + 8*r + k);
        return d;
    endfunction

    task automatic send_row_a(input logic [79:0] d, input logic m, output int waited);
        a_in_data  = d;
        a_in_mode  = m;
        a_in_valid = 1'b1;
        waited = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge CLK);
            if (a_in_ready) break;
            waited++;
        end
        if (waited >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_in_timeout: in_ready low for %0d cycles, expected high", waited);
        end
        @(posedge CLK);
        #1;
        a_in_valid = 1'b0;
    endtask

    // in_mode is inverted on rows 1..N-1 so only the row-0 value may matter.
    task automatic send_block_a(input int base, input logic m, input bit chk_lat, output int stalls);
        int w;
        stalls = 0;
        push_a(base, m);
        for (int r = 0; r < 8; r++) begin
            if (chk_lat && r == 7) check("a_no_early_valid", 80'(a_out_valid), 80'd0);
            send_row_a(row_a(base, r), (r == 0) ? m : ~m, w);
            stalls += w;
        end
        if (chk_lat) check("a_latency", 80'(a_out_valid), 80'd1);
    endtask

    task automatic drain_a();
        for (int t = 0; t < 400 && sb_a.size() != 0; t++) @(posedge CLK);
        #1;
        if (sb_a.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_drain_timeout: %0d vectors outstanding, expected 0", sb_a.size());
        end
    endtask

    task automatic push_b(input logic m);
        exp_t e;
        for (int v = 0; v < 4; v++) begin
            e.data = '0;
            for (int k = 0; k < 4; k++) begin
                if (m) e.data[k*16 +: 16] = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
                else   e.data[k*16 +: 16] = (v % 2 == 0) ? 16'hFFFF : 16'h0000;
            end
            e.idx  = 3'(v);
            e.last = (v == 3);
            sb_b.push_back(e);
        end
    endtask

    task automatic send_block_b(input logic m);
        int waited;
        push_b(m);
        for (int r = 0; r < 4; r++) begin
            b_in_data  = 64'h0000_FFFF_0000_FFFF;
            b_in_mode  = (r == 0) ? m : ~m;
            b_in_valid = 1'b1;
            waited = 0;
            for (int t = 0; t < 400; t++) begin
                @(negedge CLK);
                if (b_in_ready) break;
                waited++;
            end
            if (waited >= 400) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_in_timeout: in_ready low for %0d cycles, expected high", waited);
            end
            @(posedge CLK);
            #1;
            b_in_valid = 1'b0;
        end
    endtask

    initial begin
        int s, tot, w;
        RST = 1'b0;
        a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;

        // Reset state
        check("rst_in_ready", 80'(a_in_ready), 80'd1);
        check("rst_out_valid", 80'(a_out_valid), 80'd0);
        check("rst_out_last", 80'(a_out_last), 80'd0);
        check("rst_out_idx", 80'(a_out_idx), 80'd0);
        check("rst_out_data", a_out_data, 80'd0);
        check("rst_b_in_ready", 80'(b_in_ready), 80'd1);
        check("rst_b_out_valid", 80'(b_out_valid), 80'd0);

        // Transpose, then pass-through, one block each
        a_out_ready = 1'b1;
        send_block_a(0, 1'b0, 1'b1, s);
        drain_a();
        send_block_a(0, 1'b1, 1'b1, s);
        drain_a();

        // Continuous stream of four blocks
        fires = 0;
        tot = 0;
        for (int b = 0; b < 4; b++) begin
            send_block_a(100 * (b + 1), 1'(b % 2), 1'b0, s);
            tot += s;
        end
        drain_a();
        check("stream_stalls", 80'(tot), 80'd0);
        check("stream_fires", 80'(fires), 80'd32);
        check("stream_span", 80'(last_cyc - first_cyc), 80'd31);

        // Back-pressure: both banks fill, third block held off
        a_out_ready = 1'b0;
        send_block_a(500, 1'b0, 1'b0, s);
        send_block_a(600, 1'b1, 1'b0, s);
        check("bp_in_ready_low", 80'(a_in_ready), 80'd0);
        check("bp_out_valid", 80'(a_out_valid), 80'd1);
        a_in_data  = row_a(700, 0);
        a_in_mode  = 1'b0;
        a_in_valid = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("bp_held_off", 80'(a_in_ready), 80'd0);
        check("bp_hold_data", a_out_data, sb_a[0].data);
        check("bp_hold_idx", 80'(a_out_idx), 80'd0);
        a_out_ready = 1'b1;
        send_block_a(700, 1'b0, 1'b0, s);
        drain_a();

        // Reset with one bank mid-drain and the other partially written
        a_out_ready = 1'b0;
        send_block_a(800, 1'b0, 1'b0, s);
        for (int r = 0; r < 5; r++) send_row_a(row_a(850, r), 1'b1, w);
        a_out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        a_out_ready = 1'b0;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        check("mid_rst_in_ready", 80'(a_in_ready), 80'd1);
        check("mid_rst_out_valid", 80'(a_out_valid), 80'd0);
        check("mid_rst_out_data", a_out_data, 80'd0);
        check("mid_rst_left", 80'(sb_a.size()), 80'd5);
        sb_a.delete();
        a_out_ready = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("mid_rst_no_output", 80'(a_out_valid), 80'd0);
        send_block_a(900, 1'b0, 1'b1, s);
        drain_a();

        // 4x16 instance: full-width values, per-block latched mode
        b_out_ready = 1'b1;
        send_block_b(1'b0);
        send_block_b(1'b1);
        for (int t = 0; t < 400 && sb_b.size() != 0; t++) @(posedge CLK);
        #1;
        check("b_drained", 80'(sb_b.size()), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
